fpadder_sequencer: RTL

- Upstream feeder and result collector for the serial single-precision `fpadder`.
- Accepts operand pairs {A,B} over a valid/ready stream and buffers them in a small FIFO.
- Presents each pair to `fpadder`'s single `a` port on two consecutive cycles, waits for the adder's ready to drop and then rise, and captures `sum` into a valid/ready output register.
- Includes a watchdog that resets a hung adder and returns a quiet NaN flagged as a timeout.

---
 rtl/fpadder_pkg.sv | 15 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/fpadder_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fpadder_pkg.sv
// Shared types and constants for the serial fpadder sequencer and its operand FIFO.
package fpadder_pkg;

  typedef logic [31:0] fp32_t;

  typedef struct packed {
    fp32_t a;
    fp32_t b;
  } fp_pair_t;

  localparam fp32_t FP32_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, SEND_B, WAIT, OUTPUT, RECOVER} seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, combinational read of the head entry.
// Pushes while full and pops while empty are ignored; full ignores a same-cycle pop.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fpadder_sequencer.sv
// Feeds buffered operand pairs to the serial fpadder one at a time and returns its sums.
// Latency >= 3 cycles plus adder time; in_ready = FIFO not full, results held until out_ready.
module fpadder_sequencer
  import fpadder_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 64,
  parameter int RECOVER_CYC = 2
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  in_valid,
  output logic  in_ready,
  input  fp32_t in_a,
  input  fp32_t in_b,
  output logic  out_valid,
  input  logic  out_ready,
  output fp32_t out_sum,
  output logic  out_timeout,
  output fp32_t adder_a,
  output logic  adder_nreset,
  input  logic  adder_ready,
  input  fp32_t adder_sum
);

  localparam int FW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam int RW = $clog2(RECOVER_CYC) + 1;

  seq_state_t      state;
  fp_pair_t        head;
  fp32_t           b_hold;
  logic            full;
  logic            empty;
  logic            pop;
  logic [FW-1:0]   fifo_count;
  logic            saw_low;
  logic [CW-1:0]   wd_count;
  logic [RW-1:0]   rec_count;

  assign in_ready = !full;
  assign pop      = (state == IDLE) && !empty && adder_ready && adder_nreset;

  sync_fifo #(
    .WIDTH ($bits(fp_pair_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_valid && in_ready),
    .push_data ({in_a, in_b}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  a_fifo_count: assert property (@(posedge clock) disable iff (reset)
    ((fifo_count == '0) == empty) && (fifo_count <= FW'(DEPTH)));

  // B is latched at pop time because the FIFO entry is gone by the SEND_B cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      adder_a      <= '0;
      adder_nreset <= 1'b0;
      b_hold       <= '0;
      saw_low      <= 1'b0;
      wd_count     <= '0;
      rec_count    <= '0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_timeout  <= 1'b0;
    end else begin
      adder_nreset <= 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            adder_a <= head.a;
            b_hold  <= head.b;
            state   <= SEND_B;
          end
        end
        SEND_B: begin
          adder_a  <= b_hold;
          saw_low  <= 1'b0;
          wd_count <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wd_count <= wd_count + CW'(1);
          if (!adder_ready) saw_low <= 1'b1;
          // Completion is a falling then rising ready, never a ready that simply stays high.
          if (adder_ready && saw_low) begin
            out_sum     <= adder_sum;
            out_valid   <= 1'b1;
            out_timeout <= 1'b0;
            state       <= OUTPUT;
          end else if (wd_count == CW'(TIMEOUT - 1)) begin
            adder_nreset <= 1'b0;
            rec_count    <= '0;
            state        <= RECOVER;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        RECOVER: begin
          rec_count <= rec_count + RW'(1);
          if (rec_count == RW'(RECOVER_CYC - 1)) begin
            out_sum     <= FP32_QNAN;
            out_timeout <= 1'b1;
            out_valid   <= 1'b1;
            state       <= OUTPUT;
          end else begin
            adder_nreset <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
